// File: rtl/id_stage_if.sv
// Fetch, write-back and execute-side signals of the decode stage.
// The master side drives instructions, write-back and ex_ready.
interface id_stage_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_ready;
   logic        ex_valid;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [31:0] imm;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic        illegal;

   modport master (
      output if_valid, if_instr, wb_en, wb_rd, wb_data, ex_ready,
      input  if_ready, ex_valid, read_data1, read_data2, imm,
      input  opcode, funct3, funct7, rd, illegal
   );

   modport slave (
      input  if_valid, if_instr, wb_en, wb_rd, wb_data, ex_ready,
      output if_ready, ex_valid, read_data1, read_data2, imm,
      output opcode, funct3, funct7, rd, illegal
   );
endinterface

// File: rtl/id_stage.sv
// Decode stage: owns the register file, decodes I/R-type ops and
// holds one decoded instruction in a valid/ready output register.
module id_stage (
   input logic       clk,
   input logic       rst_n,
   id_stage_if.slave bus
);

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        illegal;
      logic        is_r;
   } id_ex_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;

   logic [31:0] rf_q [32];
   id_ex_t      out_q, out_d, dec;
   logic        valid_q, valid_d;

   logic [31:0] instr;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_val, rs2_val;
   logic        wb_wr, accept, stall;
   logic        is_i, is_r;

   assign instr  = bus.if_instr;
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign wb_wr  = bus.wb_en && (bus.wb_rd != 5'd0);
   assign is_i   = instr[6:0] == OP_IMM;
   assign is_r   = instr[6:0] == OP_REG;

   assign bus.if_ready = !valid_q || bus.ex_ready;
   assign accept       = bus.if_valid && bus.if_ready;
   assign stall        = valid_q && !bus.ex_ready;

   // Same-cycle write-back bypasses the array read
   always_comb begin
      rs1_val = rf_q[rs1];
      rs2_val = rf_q[rs2];
      if (wb_wr && bus.wb_rd == rs1) rs1_val = bus.wb_data;
      if (wb_wr && bus.wb_rd == rs2) rs2_val = bus.wb_data;
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end

   always_comb begin
      dec        = '0;
      dec.opcode = instr[6:0];
      dec.funct3 = instr[14:12];
      dec.rd     = instr[11:7];
      dec.rs1    = rs1;
      dec.rs2    = rs2;
      unique case (1'b1)
         is_i: begin
            dec.rd1 = rs1_val;
            dec.imm = {{20{instr[31]}}, instr[31:20]};
         end
         is_r: begin
            dec.rd1    = rs1_val;
            dec.rd2    = rs2_val;
            dec.funct7 = instr[31:25];
            dec.is_r   = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // A stalled operand picks up a late write-back to its source
   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      if (accept) begin
         out_d   = dec;
         valid_d = 1'b1;
      end else if (stall) begin
         if (wb_wr && bus.wb_rd == out_q.rs1 && !out_q.illegal)
            out_d.rd1 = bus.wb_data;
         if (wb_wr && bus.wb_rd == out_q.rs2 && out_q.is_r)
            out_d.rd2 = bus.wb_data;
      end else if (bus.ex_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_wr) begin
         rf_q[bus.wb_rd] <= bus.wb_data;
      end
   end

   assign bus.ex_valid   = valid_q;
   assign bus.read_data1 = out_q.rd1;
   assign bus.read_data2 = out_q.rd2;
   assign bus.imm        = out_q.imm;
   assign bus.opcode     = out_q.opcode;
   assign bus.funct3     = out_q.funct3;
   assign bus.funct7     = out_q.funct7;
   assign bus.rd         = out_q.rd;
   assign bus.illegal    = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus a random stream
// checked against a register-file/pending-instruction model.
module tb_id_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_stage_if bus();

   id_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   logic rdy_seen;

   logic [31:0] m_rf [32];
   logic        m_v, m_ill, m_isr;
   logic [31:0] m_rd1, m_rd2, m_imm;
   logic [6:0]  m_op, m_f7;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd, m_rs1, m_rs2;

   function automatic void model_reset();
      m_v = 0; m_ill = 0; m_isr = 0;
      m_rd1 = 0; m_rd2 = 0; m_imm = 0;
      m_op = 0; m_f7 = 0; m_f3 = 0;
      m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
   endfunction

   // Architectural view: a write lands first, so reads see it.
   function automatic void model_edge(
      input logic v, input logic [31:0] ins, input logic we,
      input logic [4:0] wrd, input logic [31:0] wd, input logic rdy);
      logic acc;
      logic [6:0] op;
      acc = v && (!m_v || rdy);
      if (we && wrd != 0) m_rf[wrd] = wd;
      if (acc) begin
         op    = ins[6:0];
         m_op  = op;
         m_f3  = ins[14:12];
         m_rd  = ins[11:7];
         m_rs1 = ins[19:15];
         m_rs2 = ins[24:20];
         m_isr = (op == 7'h33);
         m_ill = !(op == 7'h13 || op == 7'h33);
         m_rd1 = m_ill ? 32'd0 : m_rf[m_rs1];
         m_rd2 = m_isr ? m_rf[m_rs2] : 32'd0;
         m_imm = (op == 7'h13) ? {{20{ins[31]}}, ins[31:20]} : 32'd0;
         m_f7  = m_isr ? ins[31:25] : 7'd0;
         m_v   = 1;
      end else if (m_v && !rdy) begin
         if (we && wrd != 0 && wrd == m_rs1 && !m_ill) m_rd1 = wd;
         if (we && wrd != 0 && wrd == m_rs2 && m_isr) m_rd2 = wd;
      end else begin
         m_v = 0;
      end
   endfunction

   task automatic step(
      input logic v, input logic [31:0] ins, input logic we,
      input logic [4:0] wrd, input logic [31:0] wd, input logic rdy);
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.wb_en    = we;
      bus.wb_rd    = wrd;
      bus.wb_data  = wd;
      bus.ex_ready = rdy;
      #1;
      rdy_seen = bus.if_ready;
      @(posedge clk);
      model_edge(v, ins, we, wrd, wd, rdy);
      #1;
   endtask

   task automatic test_reset();
      bus.if_valid = 0; bus.if_instr = 0; bus.wb_en = 0;
      bus.wb_rd = 0; bus.wb_data = 0; bus.ex_ready = 0;
      rst_n = 0;
      model_reset();
      #12;
      n_vec++;
      if (bus.ex_valid !== 1'b0 || bus.illegal !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid: ex_valid=%b illegal=%b want 0 0",
                  bus.ex_valid, bus.illegal);
      end
      n_vec++;
      if ({bus.read_data1, bus.read_data2, bus.imm} !== 96'd0 ||
          {bus.opcode, bus.funct3, bus.funct7, bus.rd} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_fields: rd1=%h rd2=%h imm=%h op=%h want 0",
                  bus.read_data1, bus.read_data2, bus.imm, bus.opcode);
      end
      n_vec++;
      if (bus.if_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_if_ready: got %b want 1", bus.if_ready);
      end
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      step(0, 0, 1, 5'd5, 32'h10, 1);
      step(1, 32'hFFF28313, 0, 0, 0, 1);
      n_vec++;
      if (bus.ex_valid !== 1 || bus.read_data1 !== 32'h10 ||
          bus.imm !== 32'hFFFF_FFFF || bus.read_data2 !== 0 ||
          bus.rd !== 5'd6 || bus.illegal !== 0 || bus.funct7 !== 0) begin
         n_err++;
         $display("FAIL addi: v=%b rd1=%h imm=%h rd2=%h rd=%0d ill=%b want 1 10 ffffffff 0 6 0",
                  bus.ex_valid, bus.read_data1, bus.imm, bus.read_data2,
                  bus.rd, bus.illegal);
      end
   endtask

   task automatic test_sub();
      step(0, 0, 1, 5'd1, 32'd7, 1);
      step(0, 0, 1, 5'd2, 32'd3, 1);
      step(1, 32'h402081B3, 0, 0, 0, 1);
      n_vec++;
      if (bus.read_data1 !== 7 || bus.read_data2 !== 3 ||
          bus.funct7 !== 7'h20 || bus.funct3 !== 0 || bus.imm !== 0 ||
          bus.opcode !== 7'h33 || bus.rd !== 3) begin
         n_err++;
         $display("FAIL sub: rd1=%h rd2=%h f7=%h f3=%h imm=%h want 7 3 20 0 0",
                  bus.read_data1, bus.read_data2, bus.funct7, bus.funct3, bus.imm);
      end
   endtask

   task automatic test_bypass();
      step(1, 32'h00108233, 1, 5'd1, 32'hAA, 1);
      n_vec++;
      if (bus.read_data1 !== 32'hAA || bus.read_data2 !== 32'hAA) begin
         n_err++;
         $display("FAIL bypass: rd1=%h rd2=%h want aa aa",
                  bus.read_data1, bus.read_data2);
      end
      step(0, 0, 1, 5'd0, 32'h55, 1);
      step(1, 32'h00000393, 0, 0, 0, 1);
      n_vec++;
      if (bus.read_data1 !== 0 || bus.rd !== 5'd7) begin
         n_err++;
         $display("FAIL x0_read: rd1=%h rd=%0d want 0 7", bus.read_data1, bus.rd);
      end
      step(1, 32'h00000393, 1, 5'd0, 32'h55, 1);
      n_vec++;
      if (bus.read_data1 !== 0) begin
         n_err++;
         $display("FAIL x0_bypass: rd1=%h want 0", bus.read_data1);
      end
   endtask

   task automatic test_stall_refresh();
      step(0, 0, 0, 0, 0, 1);
      step(1, 32'h402081B3, 0, 0, 0, 0);
      n_vec++;
      if (bus.ex_valid !== 1 || bus.read_data1 !== 32'hAA ||
          bus.read_data2 !== 3) begin
         n_err++;
         $display("FAIL stall_load: v=%b rd1=%h rd2=%h want 1 aa 3",
                  bus.ex_valid, bus.read_data1, bus.read_data2);
      end
      step(1, 32'h00000393, 1, 5'd1, 32'h1234, 0);
      n_vec++;
      if (rdy_seen !== 0 || bus.read_data1 !== 32'h1234 ||
          bus.read_data2 !== 3 || bus.rd !== 3 || bus.funct7 !== 7'h20 ||
          bus.opcode !== 7'h33 || bus.imm !== 0 || bus.ex_valid !== 1) begin
         n_err++;
         $display("FAIL stall_refresh: ifr=%b rd1=%h rd2=%h rd=%0d f7=%h op=%h want 0 1234 3 3 20 33",
                  rdy_seen, bus.read_data1, bus.read_data2, bus.rd,
                  bus.funct7, bus.opcode);
      end
      step(1, 32'h00000393, 0, 0, 0, 0);
      n_vec++;
      if (rdy_seen !== 0 || bus.rd !== 3 || bus.read_data1 !== 32'h1234) begin
         n_err++;
         $display("FAIL stall_hold: ifr=%b rd=%0d rd1=%h want 0 3 1234",
                  rdy_seen, bus.rd, bus.read_data1);
      end
      step(0, 0, 0, 0, 0, 1);
      n_vec++;
      if (bus.ex_valid !== 0) begin
         n_err++;
         $display("FAIL drain: ex_valid=%b want 0", bus.ex_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins;
      for (int i = 0; i < 4; i++) begin
         ins = (32'(i) << 20) | (32'(10 + i) << 7) | 32'h13;
         step(1, ins, 0, 0, 0, 1);
         n_vec++;
         if (rdy_seen !== 1 || bus.ex_valid !== 1 ||
             bus.rd !== 5'(10 + i) || bus.imm !== 32'(i)) begin
            n_err++;
            $display("FAIL b2b[%0d]: ifr=%b v=%b rd=%0d imm=%h want 1 1 %0d %0d",
                     i, rdy_seen, bus.ex_valid, bus.rd, bus.imm, 10 + i, i);
         end
      end
   endtask

   task automatic test_illegal();
      step(1, 32'h00412083, 0, 0, 0, 1);
      n_vec++;
      if (bus.illegal !== 1 || bus.read_data1 !== 0 || bus.read_data2 !== 0 ||
          bus.imm !== 0 || bus.opcode !== 7'h03 || bus.rd !== 1 ||
          bus.ex_valid !== 1) begin
         n_err++;
         $display("FAIL illegal: ill=%b rd1=%h rd2=%h imm=%h op=%h want 1 0 0 0 03",
                  bus.illegal, bus.read_data1, bus.read_data2, bus.imm, bus.opcode);
      end
      step(0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_random();
      logic [31:0] ins, wd;
      logic [4:0]  wrd;
      logic        v, we, rdy, exp_rdy;
      for (int k = 0; k < 400; k++) begin
         ins = $urandom;
         case ($urandom_range(0, 3))
            0: ins[6:0] = 7'h13;
            1: ins[6:0] = 7'h33;
            2: ins[6:0] = 7'h03;
            default: ;
         endcase
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         v   = $urandom_range(0, 3) != 0;
         we  = $urandom_range(0, 1) != 0;
         wrd = 5'($urandom_range(0, 3));
         wd  = $urandom;
         rdy = $urandom_range(0, 2) != 0;
         exp_rdy = !m_v || rdy;
         step(v, ins, we, wrd, wd, rdy);
         n_vec++;
         if (rdy_seen !== exp_rdy || bus.ex_valid !== m_v) begin
            n_err++;
            $display("FAIL rand_hs[%0d]: ifr=%b v=%b want %b %b",
                     k, rdy_seen, bus.ex_valid, exp_rdy, m_v);
         end
         if (m_v) begin
            n_vec++;
            if (bus.read_data1 !== m_rd1 || bus.read_data2 !== m_rd2 ||
                bus.imm !== m_imm || bus.opcode !== m_op ||
                bus.funct3 !== m_f3 || bus.funct7 !== m_f7 ||
                bus.rd !== m_rd || bus.illegal !== m_ill) begin
               n_err++;
               $display("FAIL rand_out[%0d]: rd1=%h rd2=%h imm=%h op=%h ill=%b want %h %h %h %h %b",
                        k, bus.read_data1, bus.read_data2, bus.imm, bus.opcode,
                        bus.illegal, m_rd1, m_rd2, m_imm, m_op, m_ill);
            end
         end
      end
      step(0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reset_mid_stall();
      step(0, 0, 1, 5'd5, 32'h10, 1);
      step(1, 32'hFFF28313, 0, 0, 0, 0);
      #2;
      rst_n = 0;
      bus.if_valid = 0;
      bus.wb_en = 0;
      model_reset();
      #1;
      n_vec++;
      if (bus.ex_valid !== 0 || bus.read_data1 !== 0 || bus.imm !== 0 ||
          bus.rd !== 0 || bus.opcode !== 0 || bus.if_ready !== 1) begin
         n_err++;
         $display("FAIL reset_stall: v=%b rd1=%h imm=%h rd=%0d ifr=%b want 0 0 0 0 1",
                  bus.ex_valid, bus.read_data1, bus.imm, bus.rd, bus.if_ready);
      end
      #2;
      rst_n = 1;
      @(posedge clk); #1;
      step(1, 32'hFFF28313, 0, 0, 0, 1);
      n_vec++;
      if (bus.ex_valid !== 1 || bus.read_data1 !== 0 || bus.rd !== 6) begin
         n_err++;
         $display("FAIL rf_cleared: v=%b rd1=%h rd=%0d want 1 0 6",
                  bus.ex_valid, bus.read_data1, bus.rd);
      end
      step(0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sub();
      test_bypass();
      test_stall_refresh();
      test_back_to_back();
      test_illegal();
      test_random();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
